// File: rtl/fft_peak_freq_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : fft_peak_freq_detector                                             |
// | Brief  : Captures a 16-bin FFT frame and serially finds the peak-power bin. |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
module fft_peak_freq_detector #(
  parameter int DW   = 16,
  parameter int NBIN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            busy,
  output logic            done,
  output logic [3:0]      freq,
  output logic            overrun
);

  localparam int            IW         = $clog2(NBIN);
  localparam logic [IW-1:0] c_last_idx = IW'(NBIN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*DW-1:0] w_in [NBIN];
  logic [2*DW-1:0] r_buf [NBIN];
  logic [IW-1:0]   r_idx;
  logic [2*DW-1:0] r_best_mag;
  logic [IW-1:0]   r_best_idx;
  logic            r_done;
  logic [3:0]      r_freq;
  logic            r_overrun;

  logic                   w_accept;
  logic [2*DW-1:0]        w_cur;
  logic signed [2*DW-1:0] w_re_ext;
  logic signed [2*DW-1:0] w_im_ext;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic [2*DW-1:0]        w_mag;
  logic                   w_take;
  logic [IW-1:0]          w_best_idx_nxt;

  assign w_in[0]  = fft_d0;
  assign w_in[1]  = fft_d1;
  assign w_in[2]  = fft_d2;
  assign w_in[3]  = fft_d3;
  assign w_in[4]  = fft_d4;
  assign w_in[5]  = fft_d5;
  assign w_in[6]  = fft_d6;
  assign w_in[7]  = fft_d7;
  assign w_in[8]  = fft_d8;
  assign w_in[9]  = fft_d9;
  assign w_in[10] = fft_d10;
  assign w_in[11] = fft_d11;
  assign w_in[12] = fft_d12;
  assign w_in[13] = fft_d13;
  assign w_in[14] = fft_d14;
  assign w_in[15] = fft_d15;

  assign w_accept = (r_state == S_IDLE) && fft_valid;

  // Single shared squarer pair; operands are sign-extended so the 2*DW-bit product is exact.
  assign w_cur    = r_buf[r_idx];
  assign w_re_ext = {{DW{w_cur[2*DW-1]}}, w_cur[2*DW-1:DW]};
  assign w_im_ext = {{DW{w_cur[DW-1]}}, w_cur[DW-1:0]};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_mag    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  // Strict compare keeps the lowest index on ties; bin 0 always seeds the search.
  assign w_take         = (r_idx == '0) || (w_mag > r_best_mag);
  assign w_best_idx_nxt = w_take ? r_idx : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (fft_valid) w_state_nxt = S_SCAN;
      S_SCAN: if (r_idx == c_last_idx) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NBIN; k++) begin
        r_buf[k] <= w_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_best_mag <= '0;
      r_best_idx <= '0;
      r_done     <= 1'b0;
      r_freq     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_idx      <= '0;
        r_best_mag <= '0;
        r_best_idx <= '0;
      end else if (r_state == S_SCAN) begin
        if (fft_valid) begin
          r_overrun <= 1'b1;
        end
        if (w_take) begin
          r_best_mag <= w_mag;
        end
        r_best_idx <= w_best_idx_nxt;
        if (r_idx == c_last_idx) begin
          r_freq <= 4'(w_best_idx_nxt);
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state == S_SCAN);
  assign done    = r_done;
  assign freq    = r_freq;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_freq_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_fft_peak_freq_detector                                          |
// | Brief  : Scoreboard bench for the FFT peak-bin detector.                    |
// | Rev    : 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_fft_peak_freq_detector;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] drv  [16];
  logic [31:0] stim [16];
  logic        busy;
  logic        done;
  logic [3:0]  freq;
  logic        overrun;

  int          n_checks;
  int          n_errors;
  logic [3:0]  exp_q [$];
  int          lat;
  int          busy_cnt;

  fft_peak_freq_detector #(.DW(16), .NBIN(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_d0   (drv[0]),
    .fft_d1   (drv[1]),
    .fft_d2   (drv[2]),
    .fft_d3   (drv[3]),
    .fft_d4   (drv[4]),
    .fft_d5   (drv[5]),
    .fft_d6   (drv[6]),
    .fft_d7   (drv[7]),
    .fft_d8   (drv[8]),
    .fft_d9   (drv[9]),
    .fft_d10  (drv[10]),
    .fft_d11  (drv[11]),
    .fft_d12  (drv[12]),
    .fft_d13  (drv[13]),
    .fft_d14  (drv[14]),
    .fft_d15  (drv[15]),
    .busy     (busy),
    .done     (done),
    .freq     (freq),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference argmax on power; strict greater-than gives lowest-index ties.
  function automatic logic [3:0] model_argmax();
    longint re;
    longint im;
    longint mag;
    longint best;
    logic [3:0] bi;
    best = -1;
    bi   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      re  = longint'($signed(stim[k][31:16]));
      im  = longint'($signed(stim[k][15:0]));
      mag = re * re + im * im;
      if (mag > best) begin
        best = mag;
        bi   = 4'(k);
      end
    end
    return bi;
  endfunction

  task automatic fill(input logic [31:0] v);
    for (int k = 0; k < 16; k++) stim[k] = v;
  endtask

  task automatic gen_random();
    logic [15:0] a;
    logic [15:0] b;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        stim[k] = $urandom;
      end else begin
        a = 16'($urandom_range(0, 4)) - 16'd2;
        b = 16'($urandom_range(0, 4)) - 16'd2;
        stim[k] = {a << 8, b << 8};
      end
    end
  endtask

  // Caller is at a negedge; the frame is sampled at the following posedge.
  task automatic send_frame();
    for (int k = 0; k < 16; k++) drv[k] = stim[k];
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) drv[k] = 32'($urandom);
  endtask

  task automatic start_frame();
    exp_q.push_back(model_argmax());
    send_frame();
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("freq", 32'(freq), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    fft_valid = 1'b0;
    fill(32'h0);
    for (int k = 0; k < 16; k++) drv[k] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_freq", 32'(freq), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset at E5 of a scan: no done, state cleared.
    fill(32'h0100_0000);
    stim[9] = 32'h0500_0000;
    send_frame();
    repeat (4) @(negedge clk);
    check("midscan_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midscan_rst_busy", 32'(busy), 32'd0);
    check("midscan_rst_freq", 32'(freq), 32'd0);
    check("midscan_rst_overrun", 32'(overrun), 32'd0);
    repeat (20) @(negedge clk);

    // Single peak with latency and busy-width checks.
    fill(32'h0100_0000);
    stim[5] = 32'h0300_0400;
    start_frame();
    wait_done(lat, busy_cnt);
    check("peak_latency", 32'(lat), 32'd16);
    check("peak_busy_cycles", 32'(busy_cnt), 32'd16);
    check("peak_busy_at_done", 32'(busy), 32'd0);
    check("peak_freq_direct", 32'(freq), 32'd5);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("freq_held", 32'(freq), 32'd5);

    // Negative component tie, then full-scale corner bin.
    fill(32'h0);
    stim[3] = 32'hFD00_0000;
    stim[9] = 32'h0300_0000;
    start_frame();
    wait_done(lat, busy_cnt);
    check("tie_freq_direct", 32'(freq), 32'd3);
    fill(32'h0);
    stim[15] = 32'h8000_8000;
    stim[2]  = 32'h7FFF_7FFF;
    start_frame();
    wait_done(lat, busy_cnt);
    check("fullscale_freq_direct", 32'(freq), 32'd15);

    // All-zero frame, then bin 0 smallest nonzero.
    fill(32'h0);
    stim[7] = 32'h0;
    start_frame();
    wait_done(lat, busy_cnt);
    check("zero_freq_direct", 32'(freq), 32'd0);
    stim[0] = 32'h0001_0000;
    start_frame();
    wait_done(lat, busy_cnt);
    check("bin0_freq_direct", 32'(freq), 32'd0);

    // Overrun: frame B at E3 dropped; frame C right after done accepted.
    fill(32'h0010_0010);
    stim[7] = 32'h0200_0000;
    start_frame();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) drv[k] = 32'h0;
    drv[12]   = 32'h7000_0000;
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_done(lat, busy_cnt);
    check("overrun_keep_first", 32'(freq), 32'd7);
    fill(32'h0);
    stim[2] = 32'h0000_0900;
    start_frame();
    wait_done(lat, busy_cnt);
    check("after_done_accept", 32'(freq), 32'd2);
    check("overrun_sticky", 32'(overrun), 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    @(negedge clk);

    // Streaming: frames every 17 cycles.
    for (int f = 0; f < 64; f++) begin
      gen_random();
      start_frame();
      repeat (16) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("stream_overrun", 32'(overrun), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
